// File: rtl/div_if.sv
// ---------------------------------------------------------------------------
// div_if
//   Request/result bundle between the EX stage and the sequential divider.
//
//   signed_div_i  EX -> div   1 = DIV (signed), 0 = DIVU
//   opdata1_i     EX -> div   dividend
//   opdata2_i     EX -> div   divisor
//   start_i       EX -> div   request, held high until the result is consumed
//   annul_i       EX -> div   pipeline flush, aborts an in-flight division
//   result_o      div -> EX   {remainder, quotient}, valid while ready_o=1
//   ready_o       div -> EX   result valid
//
//   master : EX-stage side (drives the request)
//   slave  : divider side (drives the result)
// ---------------------------------------------------------------------------
interface div_if #(
    parameter int DW = 32
) ();
    logic            signed_div_i;
    logic [DW-1:0]   opdata1_i;
    logic [DW-1:0]   opdata2_i;
    logic            start_i;
    logic            annul_i;
    logic [2*DW-1:0] result_o;
    logic            ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
//   Multi-cycle radix-2 restoring divider for the EX-stage DIV/DIVU ops.
//   One quotient bit is produced per cycle; a DW-bit division takes DW
//   iterations plus one cycle to fix up signs and publish the result.
//   Divide-by-zero short-circuits to a zero result (no trap).
//
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset
//   bus   div_if.slave
//         signed_div_i / opdata1_i / opdata2_i / start_i / annul_i in,
//         result_o {remainder, quotient} / ready_o out (both registered)
// ---------------------------------------------------------------------------
module div_seq #(
    parameter int DW = 32
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    localparam int            CW       = $clog2(DW) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    // Two's-complement negation when en is set, pass-through otherwise.
    function automatic logic [DW-1:0] neg_if(input logic [DW-1:0] v, input logic en);
        return en ? (~v + DW'(1)) : v;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*DW:0]   dividend_q, dividend_d;
    logic [DW-1:0]   divisor_q, divisor_d;
    logic            sign1_q, sign1_d;
    logic            sign2_q, sign2_d;
    logic            signed_q, signed_d;
    logic [2*DW-1:0] result_d;
    logic            ready_d;

    logic [DW:0]          tmp;
    logic signed [DW-1:0] op1_s;
    logic signed [DW-1:0] op2_s;
    logic [DW-1:0]        op1_mag;
    logic [DW-1:0]        op2_mag;
    logic [DW-1:0]        quot_fin;
    logic [DW-1:0]        rem_fin;
    logic                 abort;

    // Operand magnitudes at capture; only signed requests take |x|.
    always_comb begin
        op1_s   = bus.opdata1_i;
        op2_s   = bus.opdata2_i;
        op1_mag = neg_if(bus.opdata1_i, bus.signed_div_i && (op1_s < 0));
        op2_mag = neg_if(bus.opdata2_i, bus.signed_div_i && (op2_s < 0));
    end

    // Trial subtraction of the divisor from the current partial remainder;
    // tmp[DW] set means the subtraction borrowed (restore).
    always_comb begin
        tmp = {1'b0, dividend_q[2*DW-1:DW]} - {1'b0, divisor_q};
    end

    // Sign fix-up: quotient is negative when operand signs differ, the
    // remainder takes the dividend's sign. -2^(DW-1)/-1 wraps naturally.
    always_comb begin
        quot_fin = neg_if(dividend_q[DW-1:0], signed_q && (sign1_q ^ sign2_q));
        rem_fin  = neg_if(dividend_q[2*DW:DW+1], signed_q && sign1_q);
    end

    assign abort = bus.annul_i || !bus.start_i;

    // Next-state and next-register logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        sign1_d    = sign1_q;
        sign2_d    = sign2_q;
        signed_d   = signed_q;
        result_d   = bus.result_o;
        ready_d    = bus.ready_o;

        unique case (state_q)
            FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d    = ON;
                        cnt_d      = '0;
                        dividend_d = {{DW{1'b0}}, op1_mag, 1'b0};
                        divisor_d  = op2_mag;
                        sign1_d    = bus.opdata1_i[DW-1];
                        sign2_d    = bus.opdata2_i[DW-1];
                        signed_d   = bus.signed_div_i;
                    end
                end
            end

            BYZERO: begin
                if (abort) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end

            ON: begin
                if (abort) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q != CNT_LAST) begin
                    if (tmp[DW]) begin
                        dividend_d = {dividend_q[2*DW-1:0], 1'b0};
                    end else begin
                        dividend_d = {tmp[DW-1:0], dividend_q[DW-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    state_d  = END;
                    result_d = {rem_fin, quot_fin};
                    ready_d  = 1'b1;
                end
            end

            END: begin
                // annul_i has no effect here: the result is already final and
                // EX releases it by dropping start_i.
                if (!bus.start_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end

            default: begin
                state_d  = FREE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            sign1_q      <= 1'b0;
            sign2_q      <= 1'b0;
            signed_q     <= 1'b0;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            sign1_q      <= sign1_d;
            sign2_q      <= sign2_d;
            signed_q     <= signed_d;
            bus.result_o <= result_d;
            bus.ready_o  <= ready_d;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq
//   Directed bench for div_seq: hand-computed DIV/DIVU vectors, latency,
//   divide-by-zero, flush, mid-operation operand changes and reset.
// ---------------------------------------------------------------------------
module tb_div_seq;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_if #(.DW(DW)) bus ();

    div_seq #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int lat;
    int rose;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    // Counts edges until ready_o rises, bounded so a dead DUT cannot hang.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.ready_o && n < 60);
    endtask

    task automatic release_and_check(input string tag);
        bus.start_i = 1'b0;
        tick();
        check({tag, "_rel_ready"}, 64'(bus.ready_o), 64'd0);
        check({tag, "_rel_result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        // Reset
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_result", bus.result_o, 64'd0);

        // 1. DIVU 100/7, latency 33 edges after capture
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        tick();
        check("divu_e0_ready", 64'(bus.ready_o), 64'd0);
        wait_ready(lat);
        check("divu_latency", 64'(lat), 64'd33);
        check("divu_100_7", bus.result_o, 64'h00000002_0000000E);
        tick();
        check("divu_hold", bus.result_o, 64'h00000002_0000000E);
        release_and_check("divu");

        // 2. DIV -7/2 and 7/-2
        bus.signed_div_i = 1'b1;
        bus.opdata1_i    = 32'hFFFFFFF9;
        bus.opdata2_i    = 32'h00000002;
        bus.start_i      = 1'b1;
        tick();
        wait_ready(lat);
        check("div_m7_2", bus.result_o, 64'hFFFFFFFF_FFFFFFFD);
        release_and_check("div_m7_2");

        bus.opdata1_i = 32'h00000007;
        bus.opdata2_i = 32'hFFFFFFFE;
        bus.start_i   = 1'b1;
        tick();
        wait_ready(lat);
        check("div_7_m2", bus.result_o, 64'h00000001_FFFFFFFD);
        release_and_check("div_7_m2");

        // 3. Divide by zero, unsigned then signed
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd5;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b1;
        tick();
        check("dz_e0_ready", 64'(bus.ready_o), 64'd0);
        tick();
        check("dz_e1_ready", 64'(bus.ready_o), 64'd1);
        check("dz_result", bus.result_o, 64'd0);
        rose = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!bus.ready_o) rose = 0;
        end
        check("dz_hold_ready", 64'(rose), 64'd1);
        release_and_check("dz");

        bus.signed_div_i = 1'b1;
        bus.opdata1_i    = 32'hFFFFFFF0;
        bus.start_i      = 1'b1;
        tick();
        wait_ready(lat);
        check("dz_signed_latency", 64'(lat), 64'd1);
        check("dz_signed_result", bus.result_o, 64'd0);
        release_and_check("dz_signed");

        // 4. annul at iteration 10, then DIVU 9/3 on the next cycle
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        tick();
        rose = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.ready_o) rose = 1;
        end
        bus.annul_i = 1'b1;
        tick();
        bus.annul_i = 1'b0;
        check("annul_ready", 64'(bus.ready_o), 64'd0);
        check("annul_result", bus.result_o, 64'd0);
        bus.opdata1_i = 32'd9;
        bus.opdata2_i = 32'd3;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_o && lat == 0) rose = 1;
            lat = 0;
        end
        wait_ready(lat);
        check("annul_no_result", 64'(rose), 64'd0);
        check("rearm_latency", 64'(lat), 64'd33);
        check("divu_9_3", bus.result_o, 64'h00000000_00000003);
        release_and_check("rearm");

        // 5. Signed overflow wrap; operands changed mid-operation
        bus.signed_div_i = 1'b1;
        bus.opdata1_i    = 32'h80000000;
        bus.opdata2_i    = 32'hFFFFFFFF;
        bus.start_i      = 1'b1;
        tick();
        repeat (5) tick();
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd12345;
        bus.opdata2_i    = 32'd0;
        wait_ready(lat);
        check("ovf_latency", 64'(lat + 5), 64'd33);
        check("div_min_m1", bus.result_o, 64'h00000000_80000000);
        release_and_check("ovf");

        // 6. rst at iteration 20, start held through release
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        tick();
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_ready", 64'(bus.ready_o), 64'd0);
        check("rst_mid_result", bus.result_o, 64'd0);
        rst = 1'b0;
        tick();
        check("rst_e0_ready", 64'(bus.ready_o), 64'd0);
        wait_ready(lat);
        check("rst_latency", 64'(lat), 64'd33);
        check("rst_divu_100_7", bus.result_o, 64'h00000002_0000000E);
        release_and_check("rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
